// File: rtl/pc_sequencer.sv
// Fetch/sequence FSM for a 4-bit CPU with a 12-bit PC: drives the PC controls,
// latches instruction bytes, resolves the jump group and strobes the rest to execute.
module pc_sequencer #(
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [INSTR_W-1:0] prog_byte,
   input  logic               flag_c,
   input  logic               flag_z,
   output logic               pc_en,
   output logic               pc_load,
   output logic               pc_rst,
   output logic [ADDR_W-1:0]  pc_addr,
   output logic [INSTR_W-1:0] instr,
   output logic               exec_stb,
   output logic               jump_taken,
   output logic [1:0]         state_o
);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_FETCH = 2'd1,
      S_OPER  = 2'd2,
      S_EXEC  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] r_operand;
   logic [3:0]         r_addr_hi;
   logic               w_taken;

   // Opcodes 0x0..0x4 form the two-byte jump group.
   function automatic logic is_jump(input logic [INSTR_W-1:0] b);
      return (b[7:4] < 4'd5);
   endfunction

   function automatic logic branch_cond(input logic [3:0] op, input logic c, input logic z);
      logic t;
      case (op)
         4'h0:    t = c;
         4'h1:    t = ~c;
         4'h2:    t = z;
         4'h3:    t = ~z;
         4'h4:    t = 1'b1;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   assign w_taken = branch_cond(r_instr[7:4], flag_c, flag_z);
   assign instr   = r_instr;
   assign state_o = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr   <= {INSTR_W{1'b0}};
         r_operand <= {INSTR_W{1'b0}};
         r_addr_hi <= 4'h0;
      end else begin
         if ((r_state == S_FETCH) && run) begin
            r_instr <= prog_byte;
         end else begin
            r_instr <= r_instr;
         end
         if (r_state == S_OPER) begin
            r_operand <= prog_byte;
            r_addr_hi <= r_instr[3:0];
         end else begin
            r_operand <= r_operand;
            r_addr_hi <= r_addr_hi;
         end
      end
   end

   // pc_rst is masked while rst is held so strobes read 0 throughout reset.
   always_comb begin
      w_next     = r_state;
      pc_en      = 1'b0;
      pc_load    = 1'b0;
      pc_rst     = 1'b0;
      exec_stb   = 1'b0;
      jump_taken = 1'b0;
      pc_addr    = {r_addr_hi, r_operand};
      case (r_state)
         S_INIT: begin
            pc_rst = ~rst;
            w_next = S_FETCH;
         end
         S_FETCH: begin
            if (run) begin
               pc_en  = 1'b1;
               w_next = is_jump(prog_byte) ? S_OPER : S_EXEC;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_OPER: begin
            pc_en   = 1'b1;
            pc_addr = {r_instr[3:0], prog_byte};
            w_next  = S_EXEC;
         end
         S_EXEC: begin
            if (is_jump(r_instr)) begin
               pc_load    = w_taken;
               jump_taken = w_taken;
            end else begin
               exec_stb = 1'b1;
            end
            w_next = S_FETCH;
         end
         default: begin
            w_next = S_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: ROM + PC environment, an instruction-level model that
// expands each fetched instruction into its expected cycle schedule, and directed programs.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        flag_c = 1'b0;
   logic        flag_z = 1'b0;
   logic [7:0]  prog_byte;
   logic        pc_en, pc_load, pc_rst, exec_stb, jump_taken;
   logic [11:0] pc_addr;
   logic [7:0]  instr;
   logic [1:0]  state_o;

   logic [7:0]  rom [0:4095];
   logic [11:0] env_pc = 12'h7FF;
   int          checks = 0;
   int          errors = 0;

   pc_sequencer #(.ADDR_W(12), .INSTR_W(8)) dut (
      .clk(clk), .rst(rst), .run(run), .prog_byte(prog_byte),
      .flag_c(flag_c), .flag_z(flag_z), .pc_en(pc_en), .pc_load(pc_load),
      .pc_rst(pc_rst), .pc_addr(pc_addr), .instr(instr), .exec_stb(exec_stb),
      .jump_taken(jump_taken), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign prog_byte = rom[env_pc];

   // External PC: load has priority over clear, clear over increment.
   always @(posedge clk) begin
      if (pc_load)     env_pc <= pc_addr;
      else if (pc_rst) env_pc <= 12'h000;
      else if (pc_en)  env_pc <= env_pc + 12'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic taken(input logic [7:0] op, input logic c, input logic z);
      case (op[7:4])
         4'h0:    return c;
         4'h1:    return !c;
         4'h2:    return z;
         4'h3:    return !z;
         4'h4:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One expected cycle of an instruction: 1 = fetch, 2 = operand, 3 = execute.
   typedef struct {
      int          kind;
      logic [7:0]  op;
      logic [11:0] tgt;
   } step_t;

   step_t       q[$];
   step_t       s;
   logic        m_init = 1'b1;
   logic [11:0] m_pc = 12'h000;
   logic [11:0] nx_pc, p1;
   logic [7:0]  m_instr = 8'h00;
   logic [11:0] m_addr = 12'h000;
   logic [7:0]  b;
   logic        pc_known, tk;
   logic [1:0]  e_state;
   logic        e_en, e_load, e_rst, e_stb, e_jt;
   logic [7:0]  e_instr;
   logic [11:0] e_addr;

   task automatic compare_cycle();
      e_state = 2'd1; e_en = 1'b0; e_load = 1'b0; e_rst = 1'b0; e_stb = 1'b0; e_jt = 1'b0;
      e_instr = m_instr; e_addr = m_addr; pc_known = 1'b1; nx_pc = m_pc;
      if (rst) begin
         q.delete();
         m_init = 1'b1; m_instr = 8'h00; m_addr = 12'h000;
         e_state = 2'd0; e_instr = 8'h00; e_addr = 12'h000; pc_known = 1'b0;
      end else if (m_init) begin
         e_state = 2'd0; e_rst = 1'b1; m_init = 1'b0; pc_known = 1'b0; nx_pc = 12'h000;
      end else begin
         if (q.size() == 0 && run) begin
            b  = rom[m_pc];
            p1 = m_pc + 12'd1;
            if (b[7:4] <= 4'h4) begin
               q.push_back('{1, b, {b[3:0], rom[p1]}});
               q.push_back('{2, b, {b[3:0], rom[p1]}});
               q.push_back('{3, b, {b[3:0], rom[p1]}});
            end else begin
               q.push_back('{1, b, 12'h000});
               q.push_back('{3, b, 12'h000});
            end
         end
         if (q.size() != 0) begin
            s = q.pop_front();
            e_state = s.kind[1:0];
            if (s.kind == 1) begin
               e_en = 1'b1; nx_pc = m_pc + 12'd1;
            end else if (s.kind == 2) begin
               e_en = 1'b1; nx_pc = m_pc + 12'd1; e_addr = s.tgt;
            end else if (s.op[7:4] <= 4'h4) begin
               tk = taken(s.op, flag_c, flag_z);
               e_load = tk; e_jt = tk; nx_pc = tk ? s.tgt : m_pc;
            end else begin
               e_stb = 1'b1;
            end
         end
      end
      chk("state", state_o, e_state);
      chk("pc_en", pc_en, e_en);
      chk("pc_load", pc_load, e_load);
      chk("pc_rst", pc_rst, e_rst);
      chk("exec_stb", exec_stb, e_stb);
      chk("jump_taken", jump_taken, e_jt);
      chk("instr", instr, e_instr);
      chk("pc_addr", pc_addr, e_addr);
      if (pc_known) chk("pc", env_pc, m_pc);
      m_pc   = nx_pc;
      m_addr = e_addr;
      if (!rst && e_en && e_state == 2'd1) m_instr = s.op;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      run = 1'b1;
      tick(n);
      run = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
      rom[12'h000] = 8'h5A;
      rom[12'h010] = 8'h4A; rom[12'h011] = 8'hBC;
      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      // Reset, then idle with run low.
      tick(3);
      rst = 1'b0;
      tick(5);
      chk("t1_pc", env_pc, 12'h000);
      chk("t1_state", state_o, 2'd1);

      // One-byte instruction 0x5A.
      run_cycles(1);
      chk("t2_instr", instr, 8'h5A);
      chk("t2_stb", exec_stb, 1'b1);
      tick(1);
      chk("t2_pc", env_pc, 12'h001);

      // NOPs up to 0x010, then JMP 0xABC.
      run_cycles(33);
      chk("t3_pc", env_pc, 12'hABC);
      chk("t3_addr", pc_addr, 12'hABC);

      // JZ not taken, then taken.
      rom[12'hABC] = 8'h23; rom[12'hABD] = 8'h45; flag_z = 1'b0;
      run_cycles(3);
      chk("t4_pc_nt", env_pc, 12'hABE);
      rom[12'hABE] = 8'h23; rom[12'hABF] = 8'h45; flag_z = 1'b1;
      run_cycles(3);
      chk("t4_pc_t", env_pc, 12'h345);

      // run drops during OPER of a JMP: jump still completes, then stall.
      rom[12'h345] = 8'h41; rom[12'h346] = 8'h23;
      run_cycles(1);
      tick(5);
      chk("t5_pc", env_pc, 12'h123);
      chk("t5_state", state_o, 2'd1);

      // JNC not taken, JC taken to 0xFFF, JMP with operand wrapped to 0x000, JNZ not taken.
      flag_c = 1'b1; flag_z = 1'b1;
      rom[12'h123] = 8'h1F; rom[12'h124] = 8'hFF;
      rom[12'h125] = 8'h0F; rom[12'h126] = 8'hFF;
      rom[12'hFFF] = 8'h47; rom[12'h000] = 8'h77;
      rom[12'h777] = 8'h38; rom[12'h778] = 8'h88;
      run_cycles(12);
      chk("tx_pc", env_pc, 12'h779);

      // rst during EXEC of a taken JC.
      rom[12'h779] = 8'h01; rom[12'h77A] = 8'h00;
      run = 1'b1;
      tick(2);
      rst = 1'b1; run = 1'b0;
      tick(2);
      chk("t6_instr", instr, 8'h00);
      chk("t6_pc_hold", env_pc, 12'h77B);
      rst = 1'b0;
      tick(1);
      chk("t6_pc_clr", env_pc, 12'h000);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
